led_pattern_encoder: RTL and testbench
======================================

Name: led_pattern_encoder

Overview:
- Output-side counterpart of the button event path: converts discrete indication commands from the MCU/AXI-GPIO into timed LED waveforms for the user.
- Accepts one command per valid/ready handshake:
  - short-blink burst
  - long-blink burst
  - steady on
  - steady off
- Generates millisecond-scale pulse and gap timing from a single clock.
- Supports active-high or active-low LED pins.

Parameters:
- CLK_HZ, 27000000, clock frequency; MS_TICKS = max(CLK_HZ/1000, 1).
- SHORT_MS, 50, on-time of a short blink in ms.
- LONG_MS, 300, on-time of a long blink in ms.
- GAP_MS, 150, off-time after every blink, including the last one, in ms.
- LED_ACTIVE_LOW, 0, 1 = led_out driven low when lit.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising clk edge.
- cmd_type  in  2  0 = short burst, 1 = long burst, 2 = steady on, 3 = steady off.
- cmd_count  in  4  number of blinks for types 0/1; 0 is treated as 1; ignored for types 2/3.
- led_out  out  1  LED drive, registered, polarity per LED_ACTIVE_LOW.
- busy  out  1  high while a blink burst is in progress.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=ST_IDLE, led_lit=0, so led_out = LED_ACTIVE_LOW.
  - busy=0, tick counter=0, pulse counter=0.
  - cmd_ready=0 while rstn=0.
  - Reset mid-burst aborts immediately; no partial pulse resumes.
- Internal lit flag led_lit; led_out = led_lit ^ LED_ACTIVE_LOW.
- States: ST_IDLE, ST_ON, ST_GAP, ST_STEADY.
- cmd_ready = rstn & (state==ST_IDLE | state==ST_STEADY). It is combinational from state and never high in ST_ON/ST_GAP. Commands arriving then are held off; the issuer must keep cmd_valid and its payload stable until accepted.
- Acceptance in ST_IDLE or ST_STEADY:
  - Type 0/1:
    - Latch ON_TICKS = MS_TICKS*SHORT_MS or MS_TICKS*LONG_MS.
    - pulses_left = (cmd_count==0 ? 1 : cmd_count).
    - tick=0; go ST_ON.
    - led_lit=1 from the next cycle (1-cycle latency).
  - Type 2: go ST_STEADY, led_lit=1 next cycle.
  - Type 3: go ST_IDLE, led_lit=0 next cycle.
- ST_ON:
  - led_lit=1, tick increments each cycle.
  - When tick==ON_TICKS-1: tick=0, pulses_left-=1, led_lit=0, go ST_GAP.
  - The LED is lit for exactly ON_TICKS cycles.
- ST_GAP:
  - led_lit=0 for exactly GAP_TICKS = MS_TICKS*GAP_MS cycles.
  - At tick==GAP_TICKS-1: tick=0.
    - If pulses_left!=0: go ST_ON with led_lit=1.
    - Otherwise go ST_IDLE.
  - The trailing gap guarantees back-to-back bursts stay visibly separated.
- busy = (state==ST_ON | state==ST_GAP), registered, aligned with led_lit.
- A burst accepted from ST_STEADY ends in ST_IDLE (LED off), not back in steady.
- Counters:
  - tick is 32-bit unsigned.
  - pulses_left is 4-bit and never wraps (decrement only when nonzero).
- Parameter widths: products are computed as 32-bit localparams; SHORT_MS, LONG_MS and GAP_MS must be ≥1 (assert in simulation).
- Simultaneous cmd_valid with a state transition out of ST_GAP into ST_IDLE: not accepted that cycle; accepted on the following cycle, when ST_IDLE makes cmd_ready=1.

Test Plan:
Bench parameters: CLK_HZ=1000 (MS_TICKS=1), SHORT_MS=5, LONG_MS=20, GAP_MS=10, LED_ACTIVE_LOW=0.
- Reset, then type=0 count=3 -> cmd_ready drops the cycle after accept; led_out high 5 / low 10 cycles, three times; busy high 45 cycles; cmd_ready returns in cycle 46 after acceptance.
- type=1 count=0 -> exactly one 20-cycle lit pulse plus 10-cycle gap, then ST_IDLE.
- type=2 then, after 7 cycles, type=0 count=1 -> led steady high; immediate accept; 5 lit cycles, 10 dark; LED remains low afterwards.
- cmd_valid held with type=0 count=2 during an active burst -> not accepted until 1 cycle after the burst completes; second burst starts exactly then, no overlap.
- rstn pulsed low for 1 cycle at cycle 12 of a long burst -> led_out=0, busy=0, cmd_ready=0 during reset; cmd_ready=1 the cycle after rstn rises; no residual pulse.
- LED_ACTIVE_LOW=1 rerun of scenario 1 -> led_out exactly inverted, including reset value 1.

Source files
------------

// File: rtl/led_pattern_encoder_if.sv
// Command handshake between the MCU/AXI-GPIO issuer and the LED pattern encoder.
// The issuer holds cmd_valid and its payload stable until cmd_ready is seen.
interface led_pattern_encoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_encoder.sv
// Turns short/long blink bursts and steady on/off commands into timed LED
// waveforms; every blink is followed by a dark gap, including the last one.
module led_pattern_encoder #(
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned SHORT_MS       = 50,
  parameter int unsigned LONG_MS        = 300,
  parameter int unsigned GAP_MS         = 150,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  led_pattern_encoder_if.slave  cmd,
  output logic                  led_out,
  output logic                  busy
);

  localparam int unsigned MS_TICKS    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam logic [31:0] SHORT_TICKS = MS_TICKS * SHORT_MS;
  localparam logic [31:0] LONG_TICKS  = MS_TICKS * LONG_MS;
  localparam logic [31:0] GAP_TICKS   = MS_TICKS * GAP_MS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP,
    ST_STEADY
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] on_ticks_q, on_ticks_d;
  logic [3:0]  pulses_q, pulses_d;
  logic        led_lit_q, led_lit_d;
  logic        busy_q, busy_d;
  logic        accept;

  assign cmd.cmd_ready = rstn & ((state_q == ST_IDLE) | (state_q == ST_STEADY));
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    on_ticks_d = on_ticks_q;
    pulses_d   = pulses_q;
    led_lit_d  = led_lit_q;
    unique case (state_q)
      ST_IDLE, ST_STEADY: begin
        if (accept) begin
          unique case (cmd.cmd_type)
            2'd0, 2'd1: begin
              on_ticks_d = (cmd.cmd_type == 2'd0) ? SHORT_TICKS : LONG_TICKS;
              pulses_d   = (cmd.cmd_count == 4'd0) ? 4'd1 : cmd.cmd_count;
              tick_d     = '0;
              led_lit_d  = 1'b1;
              state_d    = ST_ON;
            end
            2'd2: begin
              led_lit_d = 1'b1;
              state_d   = ST_STEADY;
            end
            default: begin
              led_lit_d = 1'b0;
              state_d   = ST_IDLE;
            end
          endcase
        end
      end
      ST_ON: begin
        led_lit_d = 1'b1;
        if (tick_q == on_ticks_q - 32'd1) begin
          tick_d    = '0;
          pulses_d  = (pulses_q != 4'd0) ? pulses_q - 4'd1 : pulses_q;
          led_lit_d = 1'b0;
          state_d   = ST_GAP;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      default: begin
        led_lit_d = 1'b0;
        if (tick_q == GAP_TICKS - 32'd1) begin
          tick_d = '0;
          if (pulses_q != 4'd0) begin
            led_lit_d = 1'b1;
            state_d   = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
    endcase
    // Registered from the next state so busy lines up with led_lit.
    busy_d = (state_d == ST_ON) | (state_d == ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      on_ticks_q <= '0;
      pulses_q   <= '0;
      led_lit_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      on_ticks_q <= on_ticks_d;
      pulses_q   <= pulses_d;
      led_lit_q  <= led_lit_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (SHORT_MS >= 1 && LONG_MS >= 1 && GAP_MS >= 1)
      else $error("led_pattern_encoder: SHORT_MS, LONG_MS and GAP_MS must be >= 1");
  end

  assign led_out = led_lit_q ^ LED_ACTIVE_LOW;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_pattern_encoder.sv
// Bench for led_pattern_encoder: an active-high and an active-low instance share
// one command stream and are checked every cycle against a waveform-queue model.
module tb_led_pattern_encoder;
  localparam int ON_S = 5;
  localparam int ON_L = 20;
  localparam int GAP  = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  led_pattern_encoder_if cif0 ();
  led_pattern_encoder_if cif1 ();
  assign cif1.cmd_valid = cif0.cmd_valid;
  assign cif1.cmd_type  = cif0.cmd_type;
  assign cif1.cmd_count = cif0.cmd_count;

  logic led0, led1, busy0, busy1;

  led_pattern_encoder #(
    .CLK_HZ(1000), .SHORT_MS(5), .LONG_MS(20), .GAP_MS(10), .LED_ACTIVE_LOW(1'b0)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .cmd(cif0.slave), .led_out(led0), .busy(busy0)
  );

  led_pattern_encoder #(
    .CLK_HZ(1000), .SHORT_MS(5), .LONG_MS(20), .GAP_MS(10), .LED_ACTIVE_LOW(1'b1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .cmd(cif1.slave), .led_out(led1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding the lit/dark value of every future burst
  // cycle, plus the resting level shown when no burst is queued.
  bit mq[$];
  bit mlvl = 1'b0;
  bit m_rdy;
  int m_n, m_on;

  initial forever begin
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      mlvl = 1'b0;
    end else begin
      m_rdy = (mq.size() == 0);
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_rdy && cif0.cmd_valid === 1'b1) begin
        case (cif0.cmd_type)
          2'd2: mlvl = 1'b1;
          2'd3: mlvl = 1'b0;
          default: begin
            m_n  = (cif0.cmd_count == 4'd0) ? 1 : int'(cif0.cmd_count);
            m_on = (cif0.cmd_type == 2'd0) ? ON_S : ON_L;
            mlvl = 1'b0;
            repeat (m_n) begin
              repeat (m_on) mq.push_back(1'b1);
              repeat (GAP) mq.push_back(1'b0);
            end
          end
        endcase
      end
    end
  end

  bit e_led, e_busy, e_rdy;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      e_led  = (mq.size() > 0) ? mq[0] : mlvl;
      e_busy = (mq.size() > 0);
      e_rdy  = rstn && (mq.size() == 0);
      chk_bit("led0", led0, e_led);
      chk_bit("led1", led1, !e_led);
      chk_bit("busy0", busy0, e_busy);
      chk_bit("busy1", busy1, e_busy);
      chk_bit("ready0", cif0.cmd_ready, e_rdy);
      chk_bit("ready1", cif1.cmd_ready, e_rdy);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [3:0] c, output int waited);
    cif0.cmd_type  = t;
    cif0.cmd_count = c;
    cif0.cmd_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (cif0.cmd_ready) break;
      waited++;
      if (waited > 2000) begin
        chk_int("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cif0.cmd_valid = 1'b0;
    cif0.cmd_type  = 2'($urandom);
    cif0.cmd_count = 4'($urandom);
  endtask

  // Called right after a burst is accepted; ends at the first non-busy negedge.
  task automatic measure(output int busy_n, output int lit, output int rises);
    bit prev;
    bit first;
    busy_n = 0; lit = 0; rises = 0; prev = 1'b0; first = 1'b1;
    forever begin
      @(negedge clk);
      if (first) chk_bit("ready_drop", cif0.cmd_ready, 1'b0);
      first = 1'b0;
      if (!busy0) break;
      busy_n++;
      if (led0) lit++;
      if (led0 && !prev) rises++;
      prev = led0;
      if (busy_n > 2000) break;
    end
  endtask

  typedef struct {
    logic [1:0] t;
    logic [3:0] c;
    int         exp_busy;
    int         exp_lit;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[5];
  int w, bn, lt, rs;

  initial begin
    vecs[0] = '{2'd0, 4'd3,  45,  15, 3};
    vecs[1] = '{2'd1, 4'd0,  30,  20, 1};
    vecs[2] = '{2'd0, 4'd1,  15,   5, 1};
    vecs[3] = '{2'd1, 4'd2,  60,  40, 2};
    vecs[4] = '{2'd0, 4'd15, 225, 75, 15};

    cif0.cmd_valid = 1'b0;
    cif0.cmd_type  = 2'd0;
    cif0.cmd_count = 4'd0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk_bit("rst_led0", led0, 1'b0);
    chk_bit("rst_led1", led1, 1'b1);
    chk_bit("rst_busy", busy0, 1'b0);
    chk_bit("rst_ready", cif0.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].t, vecs[i].c, w);
      chk_int("tbl_accept_wait", w, 0);
      measure(bn, lt, rs);
      chk_int("tbl_busy_cycles", bn, vecs[i].exp_busy);
      chk_int("tbl_lit_cycles", lt, vecs[i].exp_lit);
      chk_int("tbl_pulses", rs, vecs[i].exp_pulses);
      chk_bit("tbl_idle_led", led0, 1'b0);
      chk_bit("tbl_ready_back", cif0.cmd_ready, 1'b1);
      idle(2);
    end

    // Steady on, then a short burst: ends dark and idle.
    send(2'd2, 4'd0, w);
    idle(7);
    @(negedge clk);
    chk_bit("steady_led", led0, 1'b1);
    @(posedge clk);
    #1;
    send(2'd0, 4'd1, w);
    chk_int("steady_accept_wait", w, 0);
    measure(bn, lt, rs);
    chk_int("steady_burst_busy", bn, 15);
    chk_int("steady_burst_lit", lt, 5);
    idle(5);
    @(negedge clk);
    chk_bit("after_steady_led", led0, 1'b0);
    @(posedge clk);
    #1;

    // Command held during a burst: accepted one cycle after the burst ends.
    send(2'd0, 4'd1, w);
    send(2'd0, 4'd2, w);
    chk_int("held_wait", w, 15);
    measure(bn, lt, rs);
    chk_int("held_busy", bn, 30);
    chk_int("held_pulses", rs, 2);
    idle(2);

    // Reset pulse at cycle 12 of a long burst.
    send(2'd1, 4'd1, w);
    idle(11);
    rstn = 1'b0;
    @(negedge clk);
    chk_bit("rst_mid_ready", cif0.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_bit("rst_mid_led", led0, 1'b0);
    chk_bit("rst_mid_busy", busy0, 1'b0);
    chk_bit("rst_mid_ready_back", cif0.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    idle(40);

    // Random command stream, optional reset pulses, checked by the model.
    for (int k = 0; k < 60; k++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(0, 30));
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
      end else begin
        idle($urandom_range(0, 20));
      end
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end
endmodule
